// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, the zero register and
// the width of the opaque control bundle handed from decode to EX.
package mips_pkg;

  localparam int CTRL_WIDTH = 10;

  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Load-use hazard detector: the instruction in ID needs a register that the
// load currently in EX has not fetched from memory yet.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  ifid_valid,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  input  logic                  uses_rs,
  input  logic                  uses_rt,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [ADDR_WIDTH-1:0] ex_rt,
  output logic                  load_use
);

  logic ex_load;
  logic rs_hit;
  logic rt_hit;

  // A load writing $0 never produces a dependency.
  assign ex_load  = ifid_valid & ex_valid & ex_mem_read & (ex_rt != ADDR_WIDTH'(REG_ZERO));
  assign rs_hit   = uses_rs & (rs == ex_rt);
  assign rt_hit   = uses_rt & (rt == ex_rt);
  assign load_use = ex_load & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID operand stage and ID/EX pipeline register: register-file addressing,
// write-back bypass, immediate extension, load-use stall and bubble insertion.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int CTRL_WIDTH = mips_pkg::CTRL_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifid_valid,
  input  logic [WIDTH-1:0]      ifid_instr,
  input  logic [WIDTH-1:0]      ifid_pc4,
  input  logic [CTRL_WIDTH-1:0] ctrl_in,
  input  logic                  ctrl_mem_read,
  input  logic                  ctrl_uses_rs,
  input  logic                  ctrl_uses_rt,
  input  logic                  ctrl_zext,
  output logic [ADDR_WIDTH-1:0] R_addr1,
  output logic [ADDR_WIDTH-1:0] R_addr2,
  input  logic [WIDTH-1:0]      R_data1,
  input  logic [WIDTH-1:0]      R_data2,
  input  logic                  wb_regwrite,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  input  logic                  flush,
  input  logic                  stall_ext,
  output logic                  ifid_stall,
  output logic                  ex_valid,
  output logic [CTRL_WIDTH-1:0] ex_ctrl,
  output logic                  ex_mem_read,
  output logic [WIDTH-1:0]      ex_pc4,
  output logic [WIDTH-1:0]      ex_rs_data,
  output logic [WIDTH-1:0]      ex_rt_data,
  output logic [WIDTH-1:0]      ex_imm,
  output logic [ADDR_WIDTH-1:0] ex_rs,
  output logic [ADDR_WIDTH-1:0] ex_rt,
  output logic [ADDR_WIDTH-1:0] ex_rd,
  output logic [4:0]            ex_shamt,
  output logic [5:0]            ex_funct
);

  localparam logic [ADDR_WIDTH-1:0] ZR = ADDR_WIDTH'(REG_ZERO);

  logic [ADDR_WIDTH-1:0] rs, rt, rd;
  logic [4:0]            shamt;
  logic [5:0]            funct;
  logic [WIDTH-1:0]      op_a, op_b, imm;
  logic                  load_use;
  logic                  bubble;
  logic                  unused_opcode;

  assign rs    = ADDR_WIDTH'(ifid_instr[RS_MSB:RS_LSB]);
  assign rt    = ADDR_WIDTH'(ifid_instr[RT_MSB:RT_LSB]);
  assign rd    = ADDR_WIDTH'(ifid_instr[RD_MSB:RD_LSB]);
  assign shamt = ifid_instr[SHAMT_MSB:SHAMT_LSB];
  assign funct = ifid_instr[FUNCT_MSB:FUNCT_LSB];

  // Opcode is decoded by the control unit, not here.
  assign unused_opcode = &{1'b0, ifid_instr[WIDTH-1:RS_MSB+1]};

  assign R_addr1 = rs;
  assign R_addr2 = rt;

  // Write-back bypass covers the same-cycle regfile write; $0 is forced to 0
  // even if something upstream tries to write or read it as nonzero.
  always_comb begin
    op_a = R_data1;
    op_b = R_data2;
    if (wb_regwrite && wb_addr == rs) op_a = wb_data;
    if (wb_regwrite && wb_addr == rt) op_b = wb_data;
    if (rs == ZR) op_a = '0;
    if (rt == ZR) op_b = '0;
  end

  assign imm = {{(WIDTH-16){ifid_instr[IMM_MSB] & ~ctrl_zext}}, ifid_instr[IMM_MSB:IMM_LSB]};

  load_use_detect #(.ADDR_WIDTH(ADDR_WIDTH)) u_lud (
    .ifid_valid  (ifid_valid),
    .rs          (rs),
    .rt          (rt),
    .uses_rs     (ctrl_uses_rs),
    .uses_rt     (ctrl_uses_rt),
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .load_use    (load_use)
  );

  // A flush discards the ID instruction, so there is nothing left to hold.
  assign ifid_stall = (load_use & ~flush) | stall_ext;
  assign bubble     = flush | load_use | ~ifid_valid;

  // ID/EX register: hold on external stall, zero on bubble, else capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_mem_read <= 1'b0;
      ex_pc4      <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_shamt    <= '0;
      ex_funct    <= '0;
    end else if (!stall_ext) begin
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_ctrl     <= '0;
        ex_mem_read <= 1'b0;
        ex_pc4      <= '0;
        ex_rs_data  <= '0;
        ex_rt_data  <= '0;
        ex_imm      <= '0;
        ex_rs       <= '0;
        ex_rt       <= '0;
        ex_rd       <= '0;
        ex_shamt    <= '0;
        ex_funct    <= '0;
      end else begin
        ex_valid    <= 1'b1;
        ex_ctrl     <= ctrl_in;
        ex_mem_read <= ctrl_mem_read;
        ex_pc4      <= ifid_pc4;
        ex_rs_data  <= op_a;
        ex_rt_data  <= op_b;
        ex_imm      <= imm;
        ex_rs       <= rs;
        ex_rt       <= rt;
        ex_rd       <= rd;
        ex_shamt    <= shamt;
        ex_funct    <= funct;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, hand-written stall/reset
// sequences, then random traffic checked against a spec-level model.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ifid_valid, ctrl_mem_read, ctrl_uses_rs, ctrl_uses_rt, ctrl_zext;
  logic [31:0] ifid_instr, ifid_pc4, R_data1, R_data2, wb_data;
  logic [9:0]  ctrl_in;
  logic [4:0]  R_addr1, R_addr2, wb_addr;
  logic        wb_regwrite, flush, stall_ext, ifid_stall;
  logic        ex_valid, ex_mem_read;
  logic [9:0]  ex_ctrl;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_shamt;
  logic [5:0]  ex_funct;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ctrl_in(ctrl_in), .ctrl_mem_read(ctrl_mem_read),
    .ctrl_uses_rs(ctrl_uses_rs), .ctrl_uses_rt(ctrl_uses_rt), .ctrl_zext(ctrl_zext),
    .R_addr1(R_addr1), .R_addr2(R_addr2), .R_data1(R_data1), .R_data2(R_data2),
    .wb_regwrite(wb_regwrite), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .stall_ext(stall_ext), .ifid_stall(ifid_stall),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
    .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_shamt(ex_shamt), .ex_funct(ex_funct)
  );

  typedef struct {
    logic        v;
    logic [31:0] instr, pc4, rd1, rd2, wbd;
    logic        wbw;
    logic [4:0]  wba;
    logic [9:0]  ctrl;
    logic        mr, urs, urt, zext, flush, sx;
  } in_t;

  typedef struct {
    in_t         i;
    logic        stall, valid;
    logic [31:0] a, imm;
  } vec_t;

  // Expected contents of the EX stage.
  typedef struct {
    logic        valid, mr;
    logic [9:0]  ctrl;
    logic [31:0] pc4, a, b, imm;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
  } m_t;

  m_t m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic in_t mk(logic v, logic [31:0] instr, logic [31:0] rd1, logic wbw,
                             logic [4:0] wba, logic [31:0] wbd, logic mr, logic urs,
                             logic urt, logic zext, logic fl);
    in_t r;
    r.v = v; r.instr = instr; r.pc4 = 32'h0000_0104; r.rd1 = rd1; r.rd2 = 32'hBB;
    r.wbw = wbw; r.wba = wba; r.wbd = wbd; r.ctrl = 10'h2A5; r.mr = mr;
    r.urs = urs; r.urt = urt; r.zext = zext; r.flush = fl; r.sx = 1'b0;
    return r;
  endfunction

  task automatic drive(input in_t i);
    ifid_valid = i.v; ifid_instr = i.instr; ifid_pc4 = i.pc4; R_data1 = i.rd1;
    R_data2 = i.rd2; wb_regwrite = i.wbw; wb_addr = i.wba; wb_data = i.wbd;
    ctrl_in = i.ctrl; ctrl_mem_read = i.mr; ctrl_uses_rs = i.urs;
    ctrl_uses_rt = i.urt; ctrl_zext = i.zext; flush = i.flush; stall_ext = i.sx;
  endtask

  // Does the ID instruction need the value the EX-stage load is still fetching?
  function automatic logic hazard(m_t s, in_t i);
    logic [4:0] rs, rt;
    rs = i.instr[25:21];
    rt = i.instr[20:16];
    return i.v && s.valid && s.mr && s.rt != 5'd0 &&
           ((i.urs && rs == s.rt) || (i.urt && rt == s.rt));
  endfunction

  // Value a register read delivers: $0 is zero, a same-cycle WB write wins.
  function automatic logic [31:0] rdval(logic [4:0] r, logic [31:0] rf, in_t i);
    if (r == 5'd0) return 32'd0;
    if (i.wbw && i.wba == r) return i.wbd;
    return rf;
  endfunction

  function automatic m_t nxt(m_t s, in_t i);
    m_t n;
    logic [15:0] lo;
    if (i.sx) return s;
    n = '{default: '0};
    if (i.flush || hazard(s, i) || !i.v) return n;
    lo = i.instr[15:0];
    n.valid = 1'b1;
    n.mr    = i.mr;
    n.ctrl  = i.ctrl;
    n.pc4   = i.pc4;
    n.rs    = i.instr[25:21];
    n.rt    = i.instr[20:16];
    n.rd    = i.instr[15:11];
    n.shamt = i.instr[10:6];
    n.funct = i.instr[5:0];
    n.a     = rdval(n.rs, i.rd1, i);
    n.b     = rdval(n.rt, i.rd2, i);
    if (i.zext) n.imm = 32'(lo);
    else        n.imm = 32'($signed(lo));
    return n;
  endfunction

  task automatic chk_ex(input string t);
    chk({t, " ex_valid"},    32'(ex_valid),    32'(m.valid));
    chk({t, " ex_ctrl"},     32'(ex_ctrl),     32'(m.ctrl));
    chk({t, " ex_mem_read"}, 32'(ex_mem_read), 32'(m.mr));
    chk({t, " ex_pc4"},      ex_pc4,           m.pc4);
    chk({t, " ex_rs_data"},  ex_rs_data,       m.a);
    chk({t, " ex_rt_data"},  ex_rt_data,       m.b);
    chk({t, " ex_imm"},      ex_imm,           m.imm);
    chk({t, " ex_rs"},       32'(ex_rs),       32'(m.rs));
    chk({t, " ex_rt"},       32'(ex_rt),       32'(m.rt));
    chk({t, " ex_rd"},       32'(ex_rd),       32'(m.rd));
    chk({t, " ex_shamt"},    32'(ex_shamt),    32'(m.shamt));
    chk({t, " ex_funct"},    32'(ex_funct),    32'(m.funct));
  endtask

  vec_t tbl[16];

  initial begin
    logic [31:0] ins;
    in_t  ri;
    logic exp_st;

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    m = '{default: '0};
    chk_ex("reset");
    chk("reset R_addr1", 32'(R_addr1), 32'd0);
    reset = 1'b0;

    // addi $9,$8,-4 / lw $9,0($8) / add $10,$9,$8 / lw $10,0($9) / add $11,$10,$0
    tbl[0]  = '{mk(1, 32'h2109FFFC, 32'h7,  0, 0, 0,     0, 1, 0, 0, 0), 0, 1, 32'h7,  32'hFFFFFFFC};
    tbl[1]  = '{mk(1, 32'h2109FFFC, 32'h7,  0, 0, 0,     0, 1, 0, 1, 0), 0, 1, 32'h7,  32'h0000FFFC};
    tbl[2]  = '{mk(1, 32'h2109FFFC, 32'h11, 1, 8, 32'h55, 0, 1, 0, 0, 0), 0, 1, 32'h55, 32'hFFFFFFFC};
    tbl[3]  = '{mk(1, 32'h2009FFFC, 32'h11, 1, 0, 32'h55, 0, 1, 0, 0, 0), 0, 1, 32'h0,  32'hFFFFFFFC};
    tbl[4]  = '{mk(1, 32'h8D090000, 32'h20, 0, 0, 0,     1, 1, 0, 0, 0), 0, 1, 32'h20, 32'h0};
    tbl[5]  = '{mk(1, 32'h01285020, 32'h33, 0, 0, 0,     0, 1, 1, 0, 0), 1, 0, 32'h0,  32'h0};
    tbl[6]  = '{mk(1, 32'h01285020, 32'h33, 0, 0, 0,     0, 1, 1, 0, 0), 0, 1, 32'h33, 32'h5020};
    tbl[7]  = '{mk(1, 32'h8D090000, 32'h20, 0, 0, 0,     1, 1, 0, 0, 0), 0, 1, 32'h20, 32'h0};
    tbl[8]  = '{mk(1, 32'h01285020, 32'h33, 0, 0, 0,     0, 0, 1, 0, 0), 0, 1, 32'h33, 32'h5020};
    tbl[9]  = '{mk(1, 32'h8D090000, 32'h20, 0, 0, 0,     1, 1, 0, 0, 0), 0, 1, 32'h20, 32'h0};
    tbl[10] = '{mk(1, 32'h01285020, 32'h33, 0, 0, 0,     0, 1, 1, 0, 1), 0, 0, 32'h0,  32'h0};
    tbl[11] = '{mk(0, 32'h01285020, 32'h33, 0, 0, 0,     0, 1, 1, 0, 0), 0, 0, 32'h0,  32'h0};
    tbl[12] = '{mk(1, 32'h8D090000, 32'h20, 0, 0, 0,     1, 1, 0, 0, 0), 0, 1, 32'h20, 32'h0};
    tbl[13] = '{mk(1, 32'h8D2A0000, 32'h20, 0, 0, 0,     1, 1, 0, 0, 0), 1, 0, 32'h0,  32'h0};
    tbl[14] = '{mk(1, 32'h8D2A0000, 32'h20, 0, 0, 0,     1, 1, 0, 0, 0), 0, 1, 32'h20, 32'h0};
    tbl[15] = '{mk(1, 32'h01405820, 32'h44, 0, 0, 0,     0, 1, 1, 0, 0), 1, 0, 32'h0,  32'h0};

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].i);
      #1;
      chk($sformatf("vec%0d ifid_stall", k), 32'(ifid_stall), 32'(tbl[k].stall));
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d ex_valid", k),   32'(ex_valid),   32'(tbl[k].valid));
      chk($sformatf("vec%0d ex_rs_data", k), ex_rs_data,      tbl[k].a);
      chk($sformatf("vec%0d ex_imm", k),     ex_imm,          tbl[k].imm);
      chk($sformatf("vec%0d ex_rs", k), 32'(ex_rs),
          tbl[k].valid ? 32'(tbl[k].i.instr[25:21]) : 32'd0);
      chk($sformatf("vec%0d ex_rt", k), 32'(ex_rt),
          tbl[k].valid ? 32'(tbl[k].i.instr[20:16]) : 32'd0);
    end

    // External stall with a flush held across it: EX freezes, then bubbles.
    drive(tbl[0].i);
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      ri = mk(1, 32'h01285020, 32'h99, 0, 0, 0, 0, 1, 1, 0, 1);
      ri.sx = 1'b1;
      drive(ri);
      #1;
      chk($sformatf("sx%0d ifid_stall", c), 32'(ifid_stall), 32'd1);
      @(posedge clk);
      #1;
      chk($sformatf("sx%0d ex_valid", c),   32'(ex_valid), 32'd1);
      chk($sformatf("sx%0d ex_rs_data", c), ex_rs_data,    32'h7);
      chk($sformatf("sx%0d ex_imm", c),     ex_imm,        32'hFFFFFFFC);
    end
    drive(mk(1, 32'h01285020, 32'h99, 0, 0, 0, 0, 1, 1, 0, 1));
    #1;
    chk("sx-end ifid_stall", 32'(ifid_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("sx-end ex_valid", 32'(ex_valid), 32'd0);

    // Reset asserted mid-stream clears EX without waiting for an edge.
    drive(tbl[0].i);
    @(posedge clk);
    #1;
    chk("pre-reset ex_valid", 32'(ex_valid), 32'd1);
    #1 reset = 1'b1;
    #1;
    m = '{default: '0};
    chk_ex("async-reset");
    #1 reset = 1'b0;

    // Random traffic against the model; narrow register range to hit hazards.
    for (int c = 0; c < 400; c++) begin
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 3));
      ins[20:16] = 5'($urandom_range(0, 3));
      ri = mk($urandom_range(0, 7) != 0, ins, $urandom, $urandom_range(0, 1),
              5'($urandom_range(0, 3)), $urandom, $urandom_range(0, 2) == 0,
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 7) == 0);
      ri.pc4  = $urandom;
      ri.rd2  = $urandom;
      ri.ctrl = 10'($urandom);
      ri.sx   = $urandom_range(0, 7) == 0;
      drive(ri);
      #1;
      exp_st = (hazard(m, ri) && !ri.flush) || ri.sx;
      chk($sformatf("rnd%0d ifid_stall", c), 32'(ifid_stall), 32'(exp_st));
      chk($sformatf("rnd%0d R_addr1", c), 32'(R_addr1), 32'(ins[25:21]));
      m = nxt(m, ri);
      @(posedge clk);
      #1;
      chk_ex($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Instruction-decode operand stage plus the ID/EX pipeline register of the 5-stage MIPS core.
- Drives the register file read addresses from the IF/ID instruction and takes its read data.
- Applies write-back bypass, sign- or zero-extends the immediate and detects load-use hazards.
- Registers all operands and control for the EX stage, with support for stall and flush.

Parameters:
- WIDTH, 32, datapath width.
- ADDR_WIDTH, 5, register address width.
- CTRL_WIDTH, 10, width of the opaque control bundle from the control unit.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ifid_valid  in  1  IF/ID holds a real instruction.
- ifid_instr  in  WIDTH  instruction word.
- ifid_pc4  in  WIDTH  PC+4 of that instruction.
- ctrl_in  in  CTRL_WIDTH  decoded control bundle, passed through to EX.
- ctrl_mem_read  in  1  instruction is a load.
- ctrl_uses_rs  in  1  instruction reads rs.
- ctrl_uses_rt  in  1  instruction reads rt.
- ctrl_zext  in  1  zero-extend the immediate (andi/ori/xori).
- R_addr1  out  ADDR_WIDTH  register file read port 1 address (rs).
- R_addr2  out  ADDR_WIDTH  register file read port 2 address (rt).
- R_data1  in  WIDTH  register file read data 1.
- R_data2  in  WIDTH  register file read data 2.
- wb_regwrite  in  1  write-back stage is writing.
- wb_addr  in  ADDR_WIDTH  write-back destination register.
- wb_data  in  WIDTH  write-back data.
- flush  in  1  taken branch or jump resolved downstream; squash ID.
- stall_ext  in  1  downstream (memory) stall; freeze ID/EX.
- ifid_stall  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX holds a real instruction.
- ex_ctrl  out  CTRL_WIDTH  registered control bundle.
- ex_mem_read  out  1  registered load flag.
- ex_pc4  out  WIDTH  registered PC+4.
- ex_rs_data  out  WIDTH  registered rs operand.
- ex_rt_data  out  WIDTH  registered rt operand.
- ex_imm  out  WIDTH  registered extended immediate.
- ex_rs  out  ADDR_WIDTH  registered rs field.
- ex_rt  out  ADDR_WIDTH  registered rt field.
- ex_rd  out  ADDR_WIDTH  registered rd field.
- ex_shamt  out  5  registered shamt field.
- ex_funct  out  6  registered funct field.

Behaviour:
- Decode is combinational:
  - rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], shamt = instr[10:6], funct = instr[5:0].
  - R_addr1 = rs, R_addr2 = rt.
- Bypass:
  - opA = wb_data if wb_regwrite and wb_addr == rs and rs != 0; otherwise R_data1.
  - opB uses the same rule with rt and R_data2.
  - Register 0 always reads 0, with or without a bypass.
- Immediate: ex_imm = {16{instr[15] & ~ctrl_zext}, instr[15:0]}.
- load_use is asserted when all of the following hold:
  - ifid_valid and ex_valid and ex_mem_read, and ex_rt != 0;
  - and either (ctrl_uses_rs and rs == ex_rt) or (ctrl_uses_rt and rt == ex_rt).
- ifid_stall = (load_use & ~flush) | stall_ext. It is combinational.
- ID/EX register update priority, evaluated on each rising edge:
  1. reset (async): every ex_* output goes to 0, including ex_valid = 0. Asserting reset mid-operation clears state immediately.
  2. stall_ext: hold all ex_* registers unchanged. A flush arriving during stall_ext must be held asserted by its source until stall_ext drops.
  3. flush: insert a bubble.
  4. load_use: insert a bubble. IF/ID is held by ifid_stall, so the instruction retries next cycle, by which point the load has left EX.
  5. Otherwise: capture opA, opB, imm, fields, ctrl_in, ctrl_mem_read, ifid_pc4, and ex_valid = ifid_valid.
- Bubble: ex_valid = 0, ex_ctrl = 0, ex_mem_read = 0, and all data and field registers = 0, for deterministic waveforms.
- ifid_valid = 0 with no stall or flush: capture as a bubble (ex_valid = 0, ex_ctrl and ex_mem_read zeroed).
- Latency: one cycle from IF/ID to EX. Throughput is one instruction per cycle absent hazards.
- A load-use hazard costs exactly one bubble. Back-to-back loads feeding each other also cost one bubble each.

Decomposition:
- Shared package (mips_pkg) holds:
  - instruction field bit-position constants (RS_MSB/LSB, RT_*, RD_*, SHAMT_*, FUNCT_*, IMM_*);
  - the REG_ZERO constant;
  - CTRL_WIDTH.
- One combinational sub-module, load_use_detect: inputs are the ID fields, the uses flags, ex_valid, ex_mem_read and ex_rt; output is load_use.
- Bypass muxes and pipeline registers stay in id_ex_stage.

Test Plan:
- Reset asserted mid-stream while ex_valid = 1 → all ex_* outputs read 0 in the same cycle, before any clock edge.
- instr = addi $9,$8,-4 (0x2109FFFC) with R_data1 = 7 → next cycle: ex_rs = 8, ex_rt = 9, ex_imm = 0xFFFFFFFC, ex_rs_data = 7, ex_valid = 1. With ctrl_zext = 1 instead: ex_imm = 0x0000FFFC.
- wb_regwrite = 1, wb_addr = 8, wb_data = 0x55, R_data1 = 0x11, rs = 8 → ex_rs_data = 0x55. Repeat with rs = 0, wb_addr = 0 → ex_rs_data = 0.
- EX holds lw $9 (ex_mem_read = 1, ex_rt = 9), ID holds add $10,$9,$8 → ifid_stall = 1 and a bubble in the next cycle (ex_valid = 0). The following cycle captures the add with ex_valid = 1. Same test with uses_rt only and rt ≠ 9 → no stall.
- flush = 1 together with load_use = 1 → ifid_stall = 0 and ex_valid = 0 next cycle.
- stall_ext = 1 for 3 cycles with flush = 1 held → ex_* are frozen and ifid_stall = 1 for those cycles. On the first cycle after stall_ext drops, the bubble is inserted.
